// File: rtl/sub_packet_checker.sv
// Single register stage between packet_chopper and its consumer that also checks framing and length.
// It counts payload bytes per sub-packet, flags bad packets on the Eop beat and keeps statistics.
module sub_packet_checker #(
  parameter int DAT_WIDTH = 64,
  parameter int MAX_LEN   = 1024
) (
  input  logic                           Clk,
  input  logic                           Rst,
  output logic                           InBus_Rdy,
  input  logic                           InBus_Val,
  input  logic                           InBus_Sop,
  input  logic                           InBus_Eop,
  input  logic [$clog2(DAT_WIDTH/8):0]   InBus_Mod,
  input  logic [DAT_WIDTH-1:0]           InBus_Dat,
  input  logic [15:0]                    InBus_PktLen,
  input  logic [7:0]                     InBus_PktType,
  input  logic                           OutBus_Rdy,
  output logic                           OutBus_Val,
  output logic                           OutBus_Sop,
  output logic                           OutBus_Eop,
  output logic [$clog2(DAT_WIDTH/8):0]   OutBus_Mod,
  output logic [DAT_WIDTH-1:0]           OutBus_Dat,
  output logic [15:0]                    OutBus_PktLen,
  output logic [7:0]                     OutBus_PktType,
  output logic                           OutBus_Err,
  output logic                           Error,
  input  logic                           Stat_Clr,
  output logic [31:0]                    Stat_GoodCnt,
  output logic [31:0]                    Stat_BadCnt,
  output logic [31:0]                    Stat_ByteCnt
);

  localparam int NB    = DAT_WIDTH / 8;
  localparam int MOD_W = $clog2(NB) + 1;
  localparam logic [MOD_W-1:0] NB_MOD    = MOD_W'(NB);
  localparam logic [15:0]      NB_LEN    = 16'(NB);
  localparam logic [15:0]      MAX_LEN16 = 16'(MAX_LEN);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t      state;
  logic [15:0] byte_cnt;
  logic        cnt_sat;
  logic [15:0] cap_len;
  logic [7:0]  cap_type;

  logic        accept;
  logic        orphan;
  logic        abandon;
  logic        forward;
  logic        eval;
  logic        pkt_bad;
  logic [15:0] beat_bytes;
  logic [15:0] cur_len;
  logic [7:0]  cur_type;
  logic [16:0] cnt_sum;
  logic [15:0] next_cnt;
  logic        next_sat;
  logic [1:0]  bad_inc;

  assign InBus_Rdy = !OutBus_Val || OutBus_Rdy;
  assign accept    = InBus_Val && InBus_Rdy;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    beat_bytes = NB_LEN;
    if (InBus_Eop && (InBus_Mod != '0)) beat_bytes = 16'(InBus_Mod);

    // A Sop beat restarts capture, even when it abandons an open packet.
    cur_len  = InBus_Sop ? InBus_PktLen  : cap_len;
    cur_type = InBus_Sop ? InBus_PktType : cap_type;

    cnt_sum  = {1'b0, (InBus_Sop ? 16'd0 : byte_cnt)} + {1'b0, beat_bytes};
    next_sat = (!InBus_Sop && cnt_sat) || cnt_sum[16];
    next_cnt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    orphan  = accept && (state == IDLE) && !InBus_Sop;
    abandon = accept && (state == IN_PKT) && InBus_Sop;
    forward = accept && !orphan;
    eval    = forward && InBus_Eop;

    pkt_bad = (next_cnt != cur_len) || (cur_len == 16'd0) || (cur_len > MAX_LEN16) ||
              (InBus_Mod > NB_MOD) || next_sat;

    bad_inc = {1'b0, abandon} + {1'b0, eval && pkt_bad};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      cnt_sat        <= 1'b0;
      cap_len        <= '0;
      cap_type       <= '0;
      OutBus_Val     <= 1'b0;
      OutBus_Sop     <= 1'b0;
      OutBus_Eop     <= 1'b0;
      OutBus_Mod     <= '0;
      OutBus_Dat     <= '0;
      OutBus_PktLen  <= '0;
      OutBus_PktType <= '0;
      OutBus_Err     <= 1'b0;
      Error          <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      Error <= orphan || abandon || (eval && pkt_bad);

      if (forward) begin
        OutBus_Val     <= 1'b1;
        OutBus_Sop     <= InBus_Sop;
        OutBus_Eop     <= InBus_Eop;
        OutBus_Mod     <= InBus_Mod;
        OutBus_Dat     <= InBus_Dat;
        OutBus_PktLen  <= cur_len;
        OutBus_PktType <= cur_type;
        OutBus_Err     <= eval && pkt_bad;
        byte_cnt       <= next_cnt;
        cnt_sat        <= next_sat;
        cap_len        <= cur_len;
        cap_type       <= cur_type;
        state          <= InBus_Eop ? IDLE : IN_PKT;
      end else if (OutBus_Rdy) begin
        OutBus_Val <= 1'b0;
      end
    end
  end

  // Clear wins over any increment landing on the same edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Stat_GoodCnt <= '0;
      Stat_BadCnt  <= '0;
      Stat_ByteCnt <= '0;
    end else if (Stat_Clr) begin
      Stat_GoodCnt <= '0;
      Stat_BadCnt  <= '0;
      Stat_ByteCnt <= '0;
    end else begin
      Stat_BadCnt <= Stat_BadCnt + 32'(bad_inc);
      if (eval && !pkt_bad) begin
        Stat_GoodCnt <= Stat_GoodCnt + 32'd1;
        Stat_ByteCnt <= Stat_ByteCnt + 32'(cur_len);
      end
    end
  end

endmodule
